// File: rtl/led_spinner_pkg.sv
// rtl/led_spinner_pkg.sv - shared state/segment types and pattern helpers for the spinner chain
package led_spinner_pkg;

  typedef enum logic [1:0] {SPIN, COAST, STOPPED} state_t;

  typedef enum logic [2:0] {
    SEG_A = 3'd0, SEG_B = 3'd1, SEG_C = 3'd2, SEG_D = 3'd3, SEG_E = 3'd4, SEG_F = 3'd5
  } seg_idx_t;

  function automatic logic [6:0] seg_onehot(input logic [2:0] idx);
    return 7'd1 << idx;
  endfunction

  function automatic logic is_onehot6(input logic [5:0] g);
    return (g != 6'd0) && ((g & (g - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/led_spinner_chain_if.sv
// rtl/led_spinner_chain_if.sv - board-side switches/buttons and 7-seg pad bundle
interface led_spinner_chain_if #(
  parameter int N_DIGITS = 2,
  parameter int SCORE_W  = 8
);
  logic [2:0]            speed_sel_in;
  logic                  dir_in;
  logic                  stop_wheel_in;
  logic [5:0]            guess_bits_in;
  logic [7*N_DIGITS-1:0] seg_bits_out;
  logic [N_DIGITS-1:0]   dp_on_out;
  logic                  spinning_out;
  logic                  hit_pulse_out;
  logic [SCORE_W-1:0]    score_out;

  modport master (
    output speed_sel_in, dir_in, stop_wheel_in, guess_bits_in,
    input  seg_bits_out, dp_on_out, spinning_out, hit_pulse_out, score_out
  );

  modport slave (
    input  speed_sel_in, dir_in, stop_wheel_in, guess_bits_in,
    output seg_bits_out, dp_on_out, spinning_out, hit_pulse_out, score_out
  );
endinterface

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - step prescaler; period is latched at every boundary so it is never cut short
module led_step_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [TW-1:0] period_last,
  output logic          step
);
  logic [TW-1:0] cnt;
  logic [TW-1:0] last;

  assign step = (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clear || step) begin
      cnt  <= '0;
      last <= period_last;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_spinner_chain.sv
// rtl/led_spinner_chain.sv - chained 7-seg spinner: FSM, wheel position, scoring and registered pads
module led_spinner_chain
  import led_spinner_pkg::*;
#(
  parameter int N_DIGITS      = 2,
  parameter int CLK_HZ        = 50_000_000,
  parameter int BASE_STEP_HZ  = 125,
  parameter int NUM_SPEEDS    = 4,
  parameter int DEFAULT_SPEED = 3,
  parameter int COAST_STEPS   = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  led_spinner_chain_if.slave bus
);
  localparam int BASE_PER = CLK_HZ / BASE_STEP_HZ;
  localparam int MAX_PER  = BASE_PER << COAST_STEPS;
  localparam int TW       = (MAX_PER > 1) ? $clog2(MAX_PER) : 1;
  localparam int PW       = TW + 1;
  localparam int SW       = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
  localparam int CW       = (COAST_STEPS > 0) ? $clog2(COAST_STEPS + 1) : 1;
  localparam int DW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t              state, state_n;
  logic [CW-1:0]       coast_k, coast_k_n, shift;
  logic [SW-1:0]       coast_spd, spd_now, per_spd;
  logic [DW-1:0]       digit, digit_n;
  logic [2:0]          seg, seg_n;
  logic [SCORE_W-1:0]  score;
  logic [7*N_DIGITS-1:0] seg_pat_n;
  logic [N_DIGITS-1:0] dp_pat_n;
  logic [TW-1:0]       period_last;
  logic [PW-1:0]       per_tab [NUM_SPEEDS];
  logic                step, entering_stop, hit;

  for (genvar g = 0; g < NUM_SPEEDS; g++) begin : g_per
    assign per_tab[g] = PW'(CLK_HZ / (BASE_STEP_HZ << g));
  end

  assign spd_now = (int'(bus.speed_sel_in) < NUM_SPEEDS) ? SW'(bus.speed_sel_in) : SW'(DEFAULT_SPEED);

  // Period for the step that starts at this edge: coast steps stretch the speed latched at entry.
  assign per_spd     = (state == COAST) ? coast_spd : spd_now;
  assign shift       = (state_n == COAST) ? coast_k_n : '0;
  assign period_last = TW'((per_tab[per_spd] << shift) - 1'b1);

  led_step_timer #(.TW(TW)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (state == STOPPED),
    .period_last (period_last),
    .step        (step)
  );

  always_comb begin
    state_n   = state;
    coast_k_n = coast_k;
    digit_n   = digit;
    seg_n     = seg;
    if (step && state != STOPPED) begin
      if (bus.dir_in) begin
        if (seg == SEG_A) begin
          seg_n   = SEG_F;
          digit_n = (digit == '0) ? DW'(N_DIGITS - 1) : digit - 1'b1;
        end else begin
          seg_n   = seg - 3'd1;
        end
      end else begin
        if (seg == SEG_F) begin
          seg_n   = SEG_A;
          digit_n = (digit == DW'(N_DIGITS - 1)) ? '0 : digit + 1'b1;
        end else begin
          seg_n   = seg + 3'd1;
        end
      end
    end
    case (state)
      SPIN: begin
        if (step && bus.stop_wheel_in) begin
          if (COAST_STEPS == 0) begin
            state_n = STOPPED;
          end else begin
            state_n   = COAST;
            coast_k_n = CW'(1);
          end
        end
      end
      COAST: begin
        if (step) begin
          if (coast_k == CW'(COAST_STEPS)) begin
            state_n   = STOPPED;
            coast_k_n = '0;
          end else begin
            coast_k_n = coast_k + 1'b1;
          end
        end
      end
      STOPPED: if (!bus.stop_wheel_in) state_n = SPIN;
      default: state_n = SPIN;
    endcase
  end

  assign entering_stop = (state != STOPPED) && (state_n == STOPPED);
  assign hit = entering_stop && is_onehot6(bus.guess_bits_in) && bus.guess_bits_in[seg_n];

  always_comb begin
    seg_pat_n = '0;
    dp_pat_n  = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (digit_n == DW'(d)) begin
        seg_pat_n[7*d +: 7] = seg_onehot(seg_n);
        dp_pat_n[d]         = 1'b1;
      end
    end
  end

  assign bus.score_out = score;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= SPIN;
      coast_k           <= '0;
      coast_spd         <= '0;
      digit             <= '0;
      seg               <= SEG_A;
      score             <= '0;
      bus.seg_bits_out  <= '0;
      bus.dp_on_out     <= '0;
      bus.spinning_out  <= 1'b0;
      bus.hit_pulse_out <= 1'b0;
    end else begin
      state             <= state_n;
      coast_k           <= coast_k_n;
      digit             <= digit_n;
      seg               <= seg_n;
      if (state == SPIN && state_n == COAST) coast_spd <= spd_now;
      bus.seg_bits_out  <= seg_pat_n;
      bus.spinning_out  <= (state_n != STOPPED);
      bus.hit_pulse_out <= hit;
      if (entering_stop)           bus.dp_on_out <= hit ? dp_pat_n : '0;
      else if (state_n != STOPPED) bus.dp_on_out <= '0;
      if (hit && score != '1) score <= score + 1'b1;
    end
  end
endmodule

// File: tb/tb_led_spinner_chain.sv
// tb/tb_led_spinner_chain.sv - directed self-checking bench for led_spinner_chain
module tb_led_spinner_chain;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   p;
  int   got;

  always #5 clk = ~clk;

  led_spinner_chain_if #(.N_DIGITS(2), .SCORE_W(8)) bus ();

  led_spinner_chain #(
    .N_DIGITS(2), .CLK_HZ(8000), .BASE_STEP_HZ(125), .NUM_SPEEDS(4),
    .DEFAULT_SPEED(3), .COAST_STEPS(2), .SCORE_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] seg_of(input int pos);
    return 32'd1 << (7 * (pos / 6) + pos % 6);
  endfunction

  initial begin
    rst = 1'b1;
    bus.speed_sel_in  = 3'd3;
    bus.dir_in        = 1'b0;
    bus.stop_wheel_in = 1'b0;
    bus.guess_bits_in = 6'd0;
    wait_n(5);
    chk("rst_seg", 32'(bus.seg_bits_out), 32'd0);
    chk("rst_dp", 32'(bus.dp_on_out), 32'd0);
    chk("rst_spin", 32'(bus.spinning_out), 32'd0);
    chk("rst_hit", 32'(bus.hit_pulse_out), 32'd0);
    chk("rst_score", 32'(bus.score_out), 32'd0);

    // forward spin at speed 3, one step every 8 cycles, full lap
    rst = 1'b0;
    wait_n(1);
    chk("pos0_seg", 32'(bus.seg_bits_out), 32'h001);
    chk("pos0_spin", 32'(bus.spinning_out), 32'd1);
    wait_n(6);
    chk("pre_step1", 32'(bus.seg_bits_out), 32'h001);
    wait_n(1);
    chk("step1", 32'(bus.seg_bits_out), 32'h002);
    for (int k = 2; k <= 12; k++) begin
      wait_n(8);
      chk($sformatf("lap_step%0d", k), 32'(bus.seg_bits_out), seg_of(k % 12));
    end
    chk("lap_wrap", 32'(bus.seg_bits_out), 32'h001);

    // invalid code falls back to default; slow code waits for the running period
    bus.speed_sel_in = 3'd5;
    wait_n(8);
    chk("dflt_step1", 32'(bus.seg_bits_out), seg_of(1));
    wait_n(8);
    chk("dflt_step2", 32'(bus.seg_bits_out), seg_of(2));
    wait_n(3);
    bus.speed_sel_in = 3'd0;
    wait_n(5);
    chk("period_kept", 32'(bus.seg_bits_out), seg_of(3));
    wait_n(63);
    chk("slow_hold", 32'(bus.seg_bits_out), seg_of(3));
    bus.speed_sel_in = 3'd3;
    wait_n(1);
    chk("slow_step", 32'(bus.seg_bits_out), seg_of(4));

    // stop onto pos 2, coast 16 then 32 cycles, halt at pos 4 with hit
    repeat (9) wait_n(8);
    chk("pre_stop", 32'(bus.seg_bits_out), seg_of(1));
    bus.stop_wheel_in = 1'b1;
    bus.guess_bits_in = 6'b010000;
    wait_n(8);
    chk("stop_step", 32'(bus.seg_bits_out), seg_of(2));
    chk("coast_spin", 32'(bus.spinning_out), 32'd1);
    wait_n(15);
    chk("coast1_hold", 32'(bus.seg_bits_out), seg_of(2));
    wait_n(1);
    chk("coast1", 32'(bus.seg_bits_out), seg_of(3));
    wait_n(31);
    chk("coast2_hold", 32'(bus.seg_bits_out), seg_of(3));
    wait_n(1);
    chk("halt_seg", 32'(bus.seg_bits_out), 32'h010);
    chk("halt_spin", 32'(bus.spinning_out), 32'd0);
    chk("hit_dp", 32'(bus.dp_on_out), 32'b01);
    chk("hit_pulse", 32'(bus.hit_pulse_out), 32'd1);
    chk("hit_score", 32'(bus.score_out), 32'd1);
    wait_n(1);
    chk("pulse_once", 32'(bus.hit_pulse_out), 32'd0);
    chk("dp_held", 32'(bus.dp_on_out), 32'b01);
    chk("pos_frozen", 32'(bus.seg_bits_out), 32'h010);

    // release clears dp; multi-bit guess is a miss
    bus.stop_wheel_in = 1'b0;
    wait_n(1);
    chk("release_spin", 32'(bus.spinning_out), 32'd1);
    chk("release_dp", 32'(bus.dp_on_out), 32'd0);
    bus.stop_wheel_in = 1'b1;
    bus.guess_bits_in = 6'b111111;
    wait_n(8);
    chk("miss_stop_step", 32'(bus.seg_bits_out), seg_of(5));
    wait_n(48);
    chk("miss_seg", 32'(bus.seg_bits_out), seg_of(7));
    chk("miss_spin", 32'(bus.spinning_out), 32'd0);
    chk("miss_dp", 32'(bus.dp_on_out), 32'd0);
    chk("miss_pulse", 32'(bus.hit_pulse_out), 32'd0);
    chk("miss_score", 32'(bus.score_out), 32'd1);

    // reverse direction wraps from pos 0 to digit1 segment f
    bus.stop_wheel_in = 1'b0;
    bus.dir_in = 1'b1;
    wait_n(1);
    chk("rev_release", 32'(bus.spinning_out), 32'd1);
    repeat (7) wait_n(8);
    chk("rev_pos0", 32'(bus.seg_bits_out), seg_of(0));
    wait_n(8);
    chk("rev_wrap", 32'(bus.seg_bits_out), 32'h1000);

    // reset in the middle of a coast
    bus.stop_wheel_in = 1'b1;
    wait_n(8);
    chk("rev_stop_step", 32'(bus.seg_bits_out), seg_of(10));
    wait_n(5);
    rst = 1'b1;
    wait_n(1);
    chk("midrst_seg", 32'(bus.seg_bits_out), 32'd0);
    chk("midrst_spin", 32'(bus.spinning_out), 32'd0);
    chk("midrst_dp", 32'(bus.dp_on_out), 32'd0);
    chk("midrst_score", 32'(bus.score_out), 32'd0);
    rst = 1'b0;
    bus.dir_in = 1'b0;
    wait_n(1);
    chk("midrst_pos0", 32'(bus.seg_bits_out), 32'h001);
    chk("midrst_spin_on", 32'(bus.spinning_out), 32'd1);

    // 256 guaranteed hits: score saturates at 255, pulse still issued
    p = 0;
    for (int r = 0; r < 256; r++) begin
      bus.guess_bits_in = 6'(1 << ((p + 3) % 6));
      got = 0;
      for (int c = 0; c < 200 && got == 0; c++) begin
        wait_n(1);
        if (bus.hit_pulse_out === 1'b1) got = 1;
      end
      p = (p + 3) % 12;
      chk($sformatf("round%0d_pulse", r), 32'(got), 32'd1);
      chk($sformatf("round%0d_seg", r), 32'(bus.seg_bits_out), seg_of(p));
      if (r == 254) chk("score_reach_255", 32'(bus.score_out), 32'd255);
      if (r == 255) begin
        chk("score_sat", 32'(bus.score_out), 32'd255);
        chk("sat_dp", 32'(bus.dp_on_out), (p / 6 == 1) ? 32'b10 : 32'b01);
      end
      bus.stop_wheel_in = 1'b0;
      wait_n(1);
      bus.stop_wheel_in = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
